// File: rtl/counter_access_ctrl_if.sv
// Bus bundle between the CPU data port, the debug read port, the counter bank
// and the access controller.
interface counter_access_ctrl_if;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic        counter_hit;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        dbg_req;
    logic [3:0]  dbg_sel;
    logic        dbg_ack;
    logic [15:0] dbg_data;
    logic [3:0]  counter_sel;
    logic [15:0] counter_value;
    logic [15:0] counter_clear;
    logic        busy;

    modport master (
        output mem_address, mem_read, mem_write, dbg_req, dbg_sel, counter_value,
        input  counter_hit, mem_resp, mem_rdata, dbg_ack, dbg_data,
               counter_sel, counter_clear, busy
    );

    modport slave (
        input  mem_address, mem_read, mem_write, dbg_req, dbg_sel, counter_value,
        output counter_hit, mem_resp, mem_rdata, dbg_ack, dbg_data,
               counter_sel, counter_clear, busy
    );
endinterface

// File: rtl/counter_access_ctrl.sv
// Arbitrates CPU and debug accesses to the performance-counter bank, registers
// the selected counter value and issues one-hot clear pulses on CPU writes.
module counter_access_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    counter_access_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_CLEAR   = 3'd3;
    localparam logic [2:0] S_RESPOND = 3'd4;

    logic [2:0]  state;
    logic        owner_cpu;
    logic        last_grant_cpu;
    logic [3:0]  index;
    logic [3:0]  counter_sel_q;
    logic [15:0] data_reg;

    logic        cpu_valid;
    logic        grant_cpu;
    logic [3:0]  grant_index;

    assign cpu_valid   = (bus.mem_read | bus.mem_write) && (bus.mem_address >= 16'hFFF0);
    // On a tie the requester that did not win last time takes the grant.
    assign grant_cpu   = cpu_valid && (!bus.dbg_req || !last_grant_cpu);
    assign grant_index = grant_cpu ? bus.mem_address[3:0] : bus.dbg_sel;

    // NOTE: state uses non-blocking assignments and an asynchronous reset so an
    // in-flight access is abandoned immediately, including any clear pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            owner_cpu      <= 1'b0;
            last_grant_cpu <= 1'b0;
            index          <= 4'd0;
            counter_sel_q  <= 4'd0;
            data_reg       <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_valid || bus.dbg_req) begin
                        owner_cpu <= grant_cpu;
                        index     <= grant_index;
                        if (grant_cpu && bus.mem_write) begin
                            state <= S_CLEAR;
                        end else begin
                            state         <= S_SELECT;
                            counter_sel_q <= grant_index;
                        end
                    end
                end
                S_SELECT:  state <= S_CAPTURE;
                S_CAPTURE: begin
                    data_reg <= bus.counter_value;
                    state    <= S_RESPOND;
                end
                S_CLEAR: begin
                    data_reg <= 16'd0;
                    state    <= S_RESPOND;
                end
                S_RESPOND: begin
                    last_grant_cpu <= owner_cpu;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Responses and the clear pulse are decoded from registered state, so they
    // drop in the same instant reset asserts.
    assign bus.counter_hit   = cpu_valid;
    assign bus.mem_resp      = (state == S_RESPOND) && owner_cpu;
    assign bus.dbg_ack       = (state == S_RESPOND) && !owner_cpu;
    assign bus.mem_rdata     = data_reg;
    assign bus.dbg_data      = data_reg;
    assign bus.counter_sel   = counter_sel_q;
    assign bus.counter_clear = (state == S_CLEAR) ? (16'd1 << index) : 16'd0;
    assign bus.busy          = (state != S_IDLE);
endmodule

// File: tb/tb_counter_access_ctrl.sv
// Directed bench for counter_access_ctrl: responses are matched against a
// scoreboard of expected owner/data filled as each access is presented.
module tb_counter_access_ctrl;
    logic clk = 1'b0;
    logic reset;

    counter_access_ctrl_if ifc ();

    counter_access_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Counter bank model: the mux output follows counter_sel combinationally.
    logic [15:0] bank [16];
    assign ifc.counter_value = bank[ifc.counter_sel];

    typedef struct {
        bit          cpu;
        logic [15:0] data;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        sb_entry_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard entry"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, " mem_resp"}, 32'(ifc.mem_resp), 32'(e.cpu));
        check({tag, " dbg_ack"},  32'(ifc.dbg_ack),  32'(!e.cpu));
        check({tag, " data"}, 32'(e.cpu ? ifc.mem_rdata : ifc.dbg_data), 32'(e.data));
    endtask

    // Ticks until a response appears (bounded), checks the latency, then the scoreboard.
    task automatic await_resp(input string tag, input int exp_cycles);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(ifc.mem_resp || ifc.dbg_ack) && n < 20);
        check({tag, " latency"}, 32'(n), 32'(exp_cycles));
        pop_check(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 16'h0100 + 16'(i);
        reset           = 1'b1;
        ifc.mem_address = 16'h0000;
        ifc.mem_read    = 1'b0;
        ifc.mem_write   = 1'b0;
        ifc.dbg_req     = 1'b0;
        ifc.dbg_sel     = 4'd0;
        tick();
        tick();
        check("reset busy",          32'(ifc.busy),          32'd0);
        check("reset mem_resp",      32'(ifc.mem_resp),      32'd0);
        check("reset dbg_ack",       32'(ifc.dbg_ack),       32'd0);
        check("reset counter_sel",   32'(ifc.counter_sel),   32'd0);
        check("reset counter_clear", 32'(ifc.counter_clear), 32'd0);
        check("reset mem_rdata",     32'(ifc.mem_rdata),     32'd0);
        reset = 1'b0;
        tick();

        // CPU read of counter 3; later increments must not alter the returned value.
        bank[3] = 16'h1234;
        ifc.mem_address = 16'hFFF3;
        ifc.mem_read    = 1'b1;
        sb.push_back('{cpu: 1'b1, data: 16'h1234});
        tick();
        check("rd c1 counter_sel", 32'(ifc.counter_sel),   32'd3);
        check("rd c1 busy",        32'(ifc.busy),          32'd1);
        check("rd c1 clear",       32'(ifc.counter_clear), 32'd0);
        tick();
        check("rd c2 clear",       32'(ifc.counter_clear), 32'd0);
        check("rd c2 mem_resp",    32'(ifc.mem_resp),      32'd0);
        tick();
        bank[3] = 16'h1235;
        #1;
        pop_check("rd c3");
        check("rd c3 counter_sel", 32'(ifc.counter_sel),   32'd3);
        check("rd c3 clear",       32'(ifc.counter_clear), 32'd0);
        ifc.mem_read = 1'b0;
        tick();
        check("rd c4 mem_resp",    32'(ifc.mem_resp), 32'd0);
        check("rd c4 busy",        32'(ifc.busy),     32'd0);

        // CPU write of counter 5: one clear pulse, then a response with zero data.
        ifc.mem_address = 16'hFFF5;
        ifc.mem_write   = 1'b1;
        sb.push_back('{cpu: 1'b1, data: 16'h0000});
        tick();
        check("wr c1 clear",    32'(ifc.counter_clear), 32'h0020);
        check("wr c1 mem_resp", 32'(ifc.mem_resp),      32'd0);
        tick();
        check("wr c2 clear",    32'(ifc.counter_clear), 32'd0);
        pop_check("wr c2");
        ifc.mem_write = 1'b0;
        tick();
        check("wr c3 busy",     32'(ifc.busy),    32'd0);
        check("wr c3 dbg_ack",  32'(ifc.dbg_ack), 32'd0);

        // Simultaneous requests after reset: CPU, then debug (CPU re-presents, debug wins tie), then CPU.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bank[7] = 16'h7777;
        bank[2] = 16'h2222;
        ifc.mem_address = 16'hFFF7;
        ifc.mem_read    = 1'b1;
        ifc.dbg_req     = 1'b1;
        ifc.dbg_sel     = 4'd2;
        sb.push_back('{cpu: 1'b1, data: 16'h7777});
        sb.push_back('{cpu: 1'b0, data: 16'h2222});
        sb.push_back('{cpu: 1'b1, data: 16'h7777});
        await_resp("tie cpu first", 3);
        await_resp("tie dbg second", 4);
        ifc.dbg_req = 1'b0;
        await_resp("tie cpu third", 4);
        ifc.mem_read = 1'b0;
        tick();
        check("tie idle busy", 32'(ifc.busy), 32'd0);

        // Address boundary just below and at the counter window.
        bank[0] = 16'h0F0F;
        ifc.mem_address = 16'hFFEF;
        ifc.mem_read    = 1'b1;
        #1;
        check("FFEF counter_hit", 32'(ifc.counter_hit), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("FFEF busy",     32'(ifc.busy),     32'd0);
            check("FFEF mem_resp", 32'(ifc.mem_resp), 32'd0);
        end
        ifc.mem_address = 16'hFFF0;
        #1;
        check("FFF0 counter_hit", 32'(ifc.counter_hit), 32'd1);
        sb.push_back('{cpu: 1'b1, data: 16'h0F0F});
        await_resp("FFF0 read", 3);
        ifc.mem_read = 1'b0;
        tick();

        // Reset during CAPTURE aborts the access; the re-issued read completes.
        bank[4] = 16'h4444;
        ifc.mem_address = 16'hFFF4;
        ifc.mem_read    = 1'b1;
        tick();
        tick();
        check("abort capture busy", 32'(ifc.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort busy",      32'(ifc.busy),        32'd0);
        check("abort mem_rdata", 32'(ifc.mem_rdata),   32'd0);
        check("abort sel",       32'(ifc.counter_sel), 32'd0);
        tick();
        check("abort mem_resp",  32'(ifc.mem_resp),    32'd0);
        reset = 1'b0;
        sb.push_back('{cpu: 1'b1, data: 16'h4444});
        await_resp("reissue read", 3);
        ifc.mem_read = 1'b0;
        tick();

        // Reset during CLEAR cuts the pulse off immediately.
        ifc.mem_address = 16'hFFF6;
        ifc.mem_write   = 1'b1;
        tick();
        check("clr abort pulse", 32'(ifc.counter_clear), 32'h0040);
        reset = 1'b1;
        #1;
        check("clr abort cut",   32'(ifc.counter_clear), 32'd0);
        ifc.mem_write = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("clr abort mem_resp", 32'(ifc.mem_resp), 32'd0);

        // Read and write together is a write.
        ifc.mem_address = 16'hFFF1;
        ifc.mem_read    = 1'b1;
        ifc.mem_write   = 1'b1;
        sb.push_back('{cpu: 1'b1, data: 16'h0000});
        tick();
        check("rw clear", 32'(ifc.counter_clear), 32'h0002);
        tick();
        pop_check("rw resp");
        ifc.mem_read  = 1'b0;
        ifc.mem_write = 1'b0;
        tick();

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
